// File: rtl/bitty_exec_unit.sv
// Multi-cycle execute controller for the bitty core: owns the 8x16 register file and sequences
// operand latches -> external ALU -> writeback. Optional debug read port: BITTY_REG_DEBUG_EN.
module bitty_exec_unit #(
  parameter int NUM_REGS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        done,
  output logic [15:0] alu_in_a,
  output logic [15:0] alu_in_b,
  output logic [3:0]  alu_select,
  output logic        alu_mode,
  input  logic [15:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_compare,
  output logic        carry_flag,
  output logic        compare_flag
`ifdef BITTY_REG_DEBUG_EN
  ,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S0   = 2'd1,
    S1   = 2'd2,
    S2   = 2'd3
  } state_e;

  localparam logic [1:0] FMT_ALU = 2'b00;
  localparam logic [1:0] FMT_CMP = 2'b01;
  localparam logic [1:0] FMT_LDI = 2'b10;

  state_e      state_q, state_d;
  logic [15:0] ir_q;
  logic [15:0] a_q, b_q;
  logic [15:0] regs_q [NUM_REGS];
  logic        carry_q, cmp_q, done_q;

  logic        accept;
  logic [2:0]  rx, ry;
  logic [1:0]  fmt;
  logic        reg_we;
  logic [15:0] reg_wdata;

  assign rx     = ir_q[15:13];
  assign ry     = ir_q[12:10];
  assign fmt    = ir_q[1:0];
  assign accept = instr_valid & instr_ready;

  // Writeback happens only on the last sequencing cycle; LDI bypasses the ALU entirely.
  assign reg_we    = (state_q == S2) && ((fmt == FMT_ALU) || (fmt == FMT_LDI));
  assign reg_wdata = (fmt == FMT_LDI) ? {5'b0, ir_q[12:2]} : alu_result;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = S0;
      S0:      state_d = S1;
      S1:      state_d = S2;
      S2:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= 16'h0000;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      carry_q <= 1'b0;
      cmp_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S2);
      if (accept) ir_q <= instr;
      if (state_q == S0) a_q <= regs_q[rx];
      if (state_q == S1) b_q <= regs_q[ry];
      if (reg_we) regs_q[rx] <= reg_wdata;
      if ((state_q == S2) && (fmt == FMT_ALU)) carry_q <= alu_carry;
      if ((state_q == S2) && ((fmt == FMT_ALU) || (fmt == FMT_CMP))) cmp_q <= alu_compare;
    end
  end

  assign instr_ready  = (state_q == IDLE);
  assign done         = done_q;
  assign alu_in_a     = a_q;
  assign alu_in_b     = b_q;
  assign alu_select   = ir_q[9:6];
  assign alu_mode     = ir_q[5];
  assign carry_flag   = carry_q;
  assign compare_flag = cmp_q;

`ifdef BITTY_REG_DEBUG_EN
  assign dbg_data = regs_q[dbg_addr];
`endif

endmodule
